// File: rtl/mprj_uart_tx_if.sv
// rtl/mprj_uart_tx_if.sv - byte push handshake between a front end and mprj_uart_tx
//
// Purpose: groups the byte-enqueue handshake of the UART transmitter.
// Signals:
//   tx_data   8  byte to enqueue (front end -> transmitter)
//   tx_valid  1  tx_data is valid this cycle (front end -> transmitter)
//   tx_ready  1  transmitter FIFO not full (transmitter -> front end)
// Modports: master = front end (firmware / Wishbone / LA), slave = transmitter.
interface mprj_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mprj_uart_tx.sv
// rtl/mprj_uart_tx.sv - FIFO-buffered 8N1 UART transmitter for an mprj_io pin
//
// Purpose: accepts bytes through a valid/ready handshake into a DEPTH-entry
// FIFO and serialises each one as start bit, 8 data bits LSB first, stop bit.
// Each bit lasts D = max(clk_div, 2) clocks, with D latched when the frame starts.
// Optional: define MPRJ_UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
// Ports:
//   clock       system clock, rising edge
//   resetb      asynchronous active-low reset
//   tx          mprj_uart_tx_if.slave: tx_data / tx_valid / tx_ready
//   clk_div     clocks per serial bit (values below 2 act as 2)
//   enable      allows new frames to start; a running frame always completes
//   ser_tx      registered serial output, idle high
//   busy        a frame is in progress
//   fifo_level  bytes currently held in the FIFO
module mprj_uart_tx #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  mprj_uart_tx_if.slave            tx,
  input  logic [DIV_W-1:0]         clk_div,
  input  logic                     enable,
  output logic                     ser_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef MPRJ_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             avail_q;

  state_t           state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] baud_cnt;
`ifdef MPRJ_UART_TX_PARITY_EN
  logic             par_bit;
`endif

  logic             push;
  logic             pop;
  logic             bit_end;
  logic [DIV_W-1:0] div_eff;

  assign tx.tx_ready = (fifo_level != LW'(DEPTH));
  assign push        = tx.tx_valid && tx.tx_ready;
  // avail_q lags the level by one cycle, so a byte written on one edge is
  // never read out of the memory on the very next edge.
  assign pop         = (state == S_IDLE) && enable && (fifo_level != '0) && avail_q;
  assign div_eff     = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
  assign bit_end     = (baud_cnt == '0);

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= tx.tx_data;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      avail_q    <= 1'b0;
    end else begin
      avail_q <= (fifo_level != '0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      ser_tx   <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      div_lat  <= '0;
      baud_cnt <= '0;
`ifdef MPRJ_UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
`ifdef MPRJ_UART_TX_PARITY_EN
            par_bit  <= ^mem[rd_ptr];
`endif
            div_lat  <= div_eff;
            baud_cnt <= div_eff - DIV_W'(1);
            state    <= S_START;
            ser_tx   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            ser_tx   <= shift[0];
            bit_idx  <= '0;
            baud_cnt <= div_lat - DIV_W'(1);
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= div_lat - DIV_W'(1);
            if (bit_idx == 3'd7) begin
`ifdef MPRJ_UART_TX_PARITY_EN
              state  <= S_PARITY;
              ser_tx <= par_bit;
`else
              state  <= S_STOP;
              ser_tx <= 1'b1;
`endif
            end else begin
              // Shift right so the next bit to send is always at shift[1].
              shift   <= shift >> 1;
              ser_tx  <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
`ifdef MPRJ_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            ser_tx   <= 1'b1;
            baud_cnt <= div_lat - DIV_W'(1);
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            ser_tx <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          ser_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_uart_tx.sv
// tb/tb_mprj_uart_tx.sv - scoreboard testbench for mprj_uart_tx
`timescale 1ns/1ps
module tb_mprj_uart_tx;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
`ifdef MPRJ_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic                   clock = 1'b0;
  logic                   resetb = 1'b0;
  logic [DIV_W-1:0]       clk_div = DIV_W'(4);
  logic                   enable = 1'b0;
  logic                   ser_tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;

  mprj_uart_tx_if txi ();

  mprj_uart_tx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .tx         (txi),
    .clk_div    (clk_div),
    .enable     (enable),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nstarts = 0;
  int acc_cyc = 0;
  logic [7:0] exp_q[$];
  int start_hist[$];
  logic [DIV_W-1:0] div_q;
  logic in_frame = 1'b0;
  logic [7:0] cur;
  int fd;
  int fc;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    div_q <= clk_div;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: bit i of the serial frame for byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  // Monitor: detects frame starts, pops the expected byte and compares
  // the line, busy and FIFO occupancy every cycle.
  always @(negedge clock) begin
    if (!resetb) begin
      exp_q.delete();
      in_frame = 1'b0;
    end else begin
      if (!in_frame && ser_tx === 1'b0 && exp_q.size() != 0) begin
        cur      = exp_q.pop_front();
        fd       = (div_q < DIV_W'(2)) ? 2 : int'(div_q);
        fc       = 0;
        in_frame = 1'b1;
        nstarts++;
        start_hist.push_back(cyc);
      end
      check("busy", busy, in_frame);
      if (in_frame) begin
        check("ser_tx_bit", ser_tx, frame_bit(cur, fc / fd));
        fc++;
        if (fc == NB * fd) in_frame = 1'b0;
      end else begin
        check("ser_tx_idle", ser_tx, 1'b1);
      end
      check("fifo_level", fifo_level, exp_q.size());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    logic rdy_exp;
    txi.tx_valid = 1'b1;
    txi.tx_data  = b;
    @(negedge clock);
    #1;
    rdy_exp = (exp_q.size() < DEPTH);
    check("tx_ready", txi.tx_ready, rdy_exp);
    @(posedge clock);
    if (rdy_exp) exp_q.push_back(b);
    #2;
    acc_cyc      = cyc;
    txi.tx_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (nstarts < n && k < bound) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (nstarts < n) check(name, nstarts, n);
  endtask

  initial begin
    int n0, a, bc, k;
    txi.tx_valid = 1'b0;
    txi.tx_data  = 8'h00;

    // Reset then idle
    resetb = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    resetb = 1'b1;
    check("rst_ser_tx", ser_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_ready", txi.tx_ready, 1'b1);
    check("rst_fifo_level", fifo_level, 0);
    cycles(100);

    // Single byte
    clk_div = DIV_W'(4);
    enable  = 1'b1;
    n0 = nstarts;
    push(8'hA5);
    a  = acc_cyc;
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      #1;
      if (busy) bc++;
    end
    check("busy_cycles", bc, NB * 4);
    if (nstarts == n0 + 1) check("start_latency", start_hist[n0] - a, 2);
    else check("single_start", nstarts, n0 + 1);
    cycles(1);

    // Fill and stall
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    push(8'hFF);
    check("full_level", fifo_level, DEPTH);
    check("full_ready", txi.tx_ready, 1'b0);
    n0 = nstarts;
    enable = 1'b1;
    wait_starts(n0 + 1, 10, "fill_first_start");
    check("ready_after_pop", txi.tx_ready, 1'b1);
    wait_starts(n0 + 8, 8 * (NB * 4 + 1) + 20, "fill_drain");
    if (start_hist.size() >= n0 + 8)
      for (int i = 1; i < 8; i++)
        check("fill_spacing", start_hist[n0+i] - start_hist[n0+i-1], NB * 4 + 1);
    cycles(NB * 4 + 5);

    // Divisor clamp and latch
    clk_div = DIV_W'(1);
    n0 = nstarts;
    push(8'h55);
    push(8'h33);
    wait_starts(n0 + 1, 10, "div_first_start");
    cycles(3);
    clk_div = DIV_W'(8);
    wait_starts(n0 + 2, NB * 2 + 10, "div_second_start");
    if (start_hist.size() >= n0 + 2)
      check("div_spacing", start_hist[n0+1] - start_hist[n0], NB * 2 + 1);
    cycles(NB * 8 + 5);

    // Randomized traffic with varying divisors
    for (int r = 0; r < 12; r++) begin
      clk_div = DIV_W'($urandom_range(0, 6));
      push(8'($urandom));
      cycles(int'($urandom_range(0, 30)));
    end
    k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < 3000) begin
      @(negedge clock);
      #1;
      k++;
    end
    check("random_drain", exp_q.size() + int'(in_frame), 0);
    cycles(2);

    // Enable dropped mid-frame
    clk_div = DIV_W'(4);
    n0 = nstarts;
    push(8'h3C);
    push(8'hC3);
    wait_starts(n0 + 1, 10, "en_start");
    cycles(8);
    enable = 1'b0;
    cycles(NB * 8 + 10);
    check("en_hold_level", fifo_level, 1);
    check("en_hold_busy", busy, 1'b0);
    check("en_hold_starts", nstarts, n0 + 1);

    // Reset during START discards the frame and the queue
    push(8'h96);
    n0 = nstarts;
    enable = 1'b1;
    wait_starts(n0 + 1, 10, "rst_start");
    #2;
    resetb = 1'b0;
    #1;
    check("midrst_ser_tx", ser_tx, 1'b1);
    check("midrst_fifo_level", fifo_level, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tx_ready", txi.tx_ready, 1'b1);
    cycles(3);
    resetb = 1'b1;
    cycles(200);
    check("midrst_no_frames", nstarts, n0 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mprj_uart_tx.md
Name: mprj_uart_tx

Overview:
- UART transmitter in the user project area. Drives a serial line on an mprj_io pin toward the chip-level UART monitor.
- Firmware, or a Wishbone/LA front end, pushes bytes into a small FIFO through a valid/ready handshake.
- The block serialises each byte as an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
- The baud rate is set at run time by a clock divisor.

Parameters:
- DEPTH, 8: FIFO depth in bytes. Must be a power of 2, minimum 2.
- DIV_W, 16: width of the clk_div input.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- resetb  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte (not full).
- clk_div  input  DIV_W  clock cycles per serial bit.
- enable  input  1  allows new frames to start.
- ser_tx  output  1  serial output; idle high; registered.
- busy  output  1  a frame is in progress (state != IDLE).
- fifo_level  output  $clog2(DEPTH)+1  bytes currently held in the FIFO.

Behaviour:
- Reset (resetb low, asynchronous):
  - ser_tx=1, busy=0, tx_ready=1, fifo_level=0.
  - FIFO pointers cleared; FSM goes to IDLE; bit and baud counters cleared.
  - Reset asserted mid-frame aborts the frame: ser_tx goes high immediately and queued bytes are discarded.
- Push:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready = (fifo_level != DEPTH), combinational from registered state.
  - tx_valid while full is ignored; no overwrite, no error flag.
- Pop:
  - Occurs only in IDLE, when enable=1 and fifo_level!=0.
  - The head byte is loaded into the shift register, the FSM moves to START, and ser_tx is driven 0 from that edge.
  - A push into an empty FIFO while idle produces the ser_tx falling edge on the 2nd rising edge after the accepting edge.
- Simultaneous push and pop on the same edge: fifo_level is unchanged; both take effect.
  - When full, no push is possible that cycle; tx_ready rises the cycle after the pop.
- Bit timing:
  - The effective divisor D = max(clk_div, 2) is latched at pop.
  - Later changes to clk_div affect only the next frame.
  - Each bit lasts exactly D clock cycles; the baud counter counts D-1 down to 0.
- FSM (2-bit state, plus PARITY when enabled):
  - IDLE -> START on pop.
  - START -> DATA after D cycles, ser_tx=0.
  - DATA: 8 bits, bit index 0..7, LSB first, D cycles each. -> STOP after bit 7.
  - STOP: ser_tx=1 for D cycles, then -> IDLE.
  - Frame length is exactly 10*D cycles.
- Back-to-back frames:
  - IDLE is occupied for exactly one cycle between frames, so there are 10*D+1 cycles from one start edge to the next.
  - ser_tx stays 1 through that IDLE cycle.
- enable:
  - Deassertion mid-frame does not abort; the current frame completes and the FSM then holds in IDLE.
  - Pushes are still accepted while disabled.
- busy = 1 in START/DATA/PARITY/STOP.

Optional Feature:
- Macro: MPRJ_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even parity of the data byte (XOR of the 8 bits) for D cycles.
  - Frame length is 11*D; back-to-back spacing is 11*D+1.
- Undefined:
  - No PARITY state and no parity logic; 8N1 exactly as above.

Test Plan:
- Reset then idle: hold resetb=0 for 5 cycles, release, no pushes -> ser_tx=1, busy=0, tx_ready=1, fifo_level=0 for 100 cycles.
- Single byte: clk_div=4, enable=1, push 0xA5.
  - ser_tx falls 2 edges after the accept.
  - Sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - busy high for 40 cycles.
  - With MPRJ_UART_TX_PARITY_EN, a parity bit 0 precedes stop and busy lasts 44 cycles.
- Fill and stall: enable=0, push 8 bytes 0x00..0x07 -> fifo_level=8, tx_ready=0.
  - A 9th push of 0xFF is not accepted.
  - Set enable=1: the first pop raises tx_ready next cycle.
  - Serial output decodes to 0x00..0x07 in order, start bits spaced 41 cycles at clk_div=4.
- Divisor clamp and latch: clk_div=1 with 0x55 pushed -> bit period 2 cycles.
  - Change clk_div to 8 mid-frame: the current frame keeps period 2; the next frame uses 8.
- Enable and reset mid-frame:
  - Deassert enable during DATA with 2 bytes queued -> the frame completes, then IDLE holds with fifo_level=1.
  - Re-enable; pulse resetb low during START -> ser_tx=1 immediately, fifo_level=0, no further frames.
